spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  System-clock-side sequencer for the SPI memory slave. It accepts one parallel read/write
//  request at a time and produces a complete SPI frame on spi_sclk/spi_cs_n/spi_mosi.
//  Frame: 7-bit address MSB-first, then R/W bit (1=read), then 8 data bits. For reads it
//  samples spi_miso and returns the byte. It is the only master driving the memory's pins.
// PARAMETERS
//  CLK_DIV  4  clk cycles per spi_sclk half-period; legal range >=1
//  ADDR_W   7  address width; the command byte is ADDR_W+1 bits
//  DATA_W   8  data byte width
//  CS_GAP   2  minimum spi_cs_n-high time between frames, in sclk periods
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid&&req_ready
//  req_rw       in   1       1=read, 0=write
//  req_addr     in   ADDR_W  target address
//  req_wdata    in   DATA_W  write data; ignored on reads
//  rsp_valid    out  1       1-cycle pulse at frame completion (reads and writes)
//  rsp_rdata    out  DATA_W  read byte; 0 after a write; held until the next rsp_valid
//  busy         out  1       ~req_ready
//  spi_sclk     out  1       SPI clock, idles low; slave samples on rising edge
//  spi_cs_n     out  1       chip select, active low
//  spi_mosi     out  1       serial data to slave
//  spi_miso     in   1       serial data from slave
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rsp_valid=0,
//   rsp_rdata=0, req_ready=1. Mid-frame reset aborts immediately; no rsp_valid is issued.
//  All outputs are registered except req_ready=(state==IDLE) and busy.
//  States: IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
//  IDLE: req_ready=1. On accept, latch rw/addr/wdata into a 16-bit tx shift register:
//   {addr, rw, wdata or 0}. Go to SETUP.
//  SETUP: spi_cs_n=0, spi_mosi=tx[15], spi_sclk=0, for CLK_DIV clocks.
//  SHIFT: 16 sclk periods. Each period is CLK_DIV clocks high followed by CLK_DIV clocks low.
//   On the low->high transition, when the bit index is >=8 and rw=1, shift spi_miso into the
//   rx register (MSB first). On the high->low transition, shift tx and drive spi_mosi with
//   the next bit. A 5-bit bit counter goes 0..15; exit after the low phase of bit 15.
//   During the data phase of a read, spi_mosi=0.
//  DONE: one clock. spi_cs_n<=1, rsp_valid<=1, rsp_rdata<=rw?rx:0.
//  GAP: spi_cs_n=1 for CS_GAP*2*CLK_DIV clocks, then IDLE.
//  Timing: spi_cs_n falls on the clock after acceptance and stays low exactly 33*CLK_DIV
//   clocks. rsp_valid coincides with the spi_cs_n rise. req_ready returns
//   CS_GAP*2*CLK_DIV+1 clocks after that.
//  req_valid while busy is ignored, with no queuing. A request present in the first IDLE
//   cycle is accepted in that cycle.
//  spi_miso X/Z is sampled as-is; it does not affect sequencing.
//  The divider counter is $clog2(CLK_DIV)+1 bits; it reloads at every phase boundary and
//   never wraps mid-phase.
// STRUCTURE
//  spi_pkg: state localparams (one-hot, 5 states), CMD_BITS=ADDR_W+1, FRAME_BITS=16,
//   RW_READ=1'b1. The slave FSM shares this package.
//  Sub-module spi_clk_gen: CLK_DIV divider with en input and rise_stb/fall_stb outputs, which
//   the FSM consumes. Everything else stays in one always_ff FSM and datapath.
// TESTING  (bench CLK_DIV=2, CS_GAP=2, with a behavioural slave model)
//  Write addr=7'h2A, data=8'hC5 -> mosi at the 16 sclk rises = 0101010_0_11000101;
//   cs_n low 66 clks; one rsp_valid; rsp_rdata=0.
//  Read addr=7'h05, slave returns 8'h3C -> mosi cmd = 0000101_1, data phase 0;
//   rsp_rdata=8'h3C on rsp_valid.
//  req_valid held high for two writes -> cs_n high >=8 clks between frames; second
//   accepted 9 clks after the first rsp_valid.
//  rst_n low during sclk period 5 -> cs_n=1 and sclk=0 in the same cycle, no rsp_valid;
//   after release a read of 7'h7F completes normally.
//  req_valid pulsed while busy -> ignored; exactly one frame and one rsp_valid.
//  CLK_DIV=1 build -> sclk period 2 clks, cs_n low 33 clks, read data correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory master/slave pair: state encoding,
// frame geometry and the divider-width helper.
package spi_pkg;

    // Default frame geometry: 7-bit address + R/W bit, then one data byte.
    localparam int unsigned ADDR_W_DFLT = 7;
    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned CMD_BITS    = ADDR_W_DFLT + 1;
    localparam int unsigned FRAME_BITS  = CMD_BITS + DATA_W_DFLT;

    // Value of the R/W bit that marks a read.
    localparam logic RW_READ = 1'b1;

    // One-hot sequencer states.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_SETUP = 5'b00010,
        ST_SHIFT = 5'b00100,
        ST_DONE  = 5'b01000,
        ST_GAP   = 5'b10000
    } spi_state_t;

    // Width of the half-period divider counter; one spare bit so the
    // terminal count CLK_DIV-1 is always representable, even for CLK_DIV=1.
    function automatic int unsigned div_cnt_w(input int unsigned div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider for the SPI clock. While en is high it counts CLK_DIV
// system clocks per phase and flags the end of a low phase (rise_stb) or of
// a high phase (fall_stb). Dropping en returns it to the start of a low phase.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned        CNT_W = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0]   TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             phase_hi_r;
    logic             term_s;

    assign term_s   = (cnt_r == TERM);
    assign rise_stb = en & term_s & ~phase_hi_r;
    assign fall_stb = en & term_s & phase_hi_r;

    // Phase counter: reload at every phase boundary, restart low when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            phase_hi_r <= 1'b0;
        end else if (!en) begin
            cnt_r      <= {CNT_W{1'b0}};
            phase_hi_r <= 1'b0;
        end else if (term_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            phase_hi_r <= ~phase_hi_r;
        end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// System-clock-side SPI master for the memory slave. Takes one read/write
// request at a time and produces a complete frame:
//   address (MSB first), R/W bit, data byte.
// Reads capture spi_miso during the data byte and return it on rsp_rdata.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    // Frame geometry derived from the parameters.
    localparam int unsigned       TX_W     = ADDR_W + 1 + DATA_W;
    localparam int unsigned       BIT_W    = $clog2(TX_W) + 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(TX_W);
    localparam logic [BIT_W-1:0]  RX_FIRST = BIT_W'(ADDR_W + 1);

    // Chip-select gap between frames (CS_GAP is expected to be >= 1).
    localparam int unsigned       GAP_CLKS = CS_GAP * 2 * CLK_DIV;
    localparam int unsigned       GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CLKS - 1);

    spi_state_t        state_r;
    logic [TX_W-1:0]   tx_r;
    logic [DATA_W-1:0] rx_r;
    logic              rw_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              sclk_r;
    logic              cs_n_r;
    logic              mosi_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic              clk_en_s;
    logic              rise_stb_s;
    logic              fall_stb_s;

    // The divider only runs while chip select is asserted and the frame is live.
    assign clk_en_s = (state_r == ST_SETUP) || (state_r == ST_SHIFT);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = ~req_ready;
    assign spi_sclk  = sclk_r;
    assign spi_cs_n  = cs_n_r;
    assign spi_mosi  = mosi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

    // Frame sequencer and datapath: accept, shift out/in, respond, hold CS gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tx_r        <= {TX_W{1'b0}};
            rx_r        <= {DATA_W{1'b0}};
            rw_r        <= 1'b0;
            bit_cnt_r   <= {BIT_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            sclk_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Data field is forced to zero on reads so mosi
                        // stays low through the data phase.
                        tx_r      <= {req_addr, req_rw,
                                      (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata};
                        rw_r      <= req_rw;
                        rx_r      <= {DATA_W{1'b0}};
                        bit_cnt_r <= {BIT_W{1'b0}};
                        cs_n_r    <= 1'b0;
                        sclk_r    <= 1'b0;
                        mosi_r    <= req_addr[ADDR_W-1];
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // First rising edge: bit 0 is always a command bit, no capture.
                    if (rise_stb_s) begin
                        sclk_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise_stb_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            // Low phase of the last bit is over: close the frame.
                            // cs_n rises and rsp_valid pulses in the same cycle.
                            cs_n_r      <= 1'b1;
                            mosi_r      <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= (rw_r == RW_READ) ? rx_r : {DATA_W{1'b0}};
                            state_r     <= ST_DONE;
                        end else begin
                            sclk_r <= 1'b1;
                            if ((rw_r == RW_READ) && (bit_cnt_r >= RX_FIRST)) begin
                                rx_r <= {rx_r[DATA_W-2:0], spi_miso};
                            end
                        end
                    end else if (fall_stb_s) begin
                        sclk_r    <= 1'b0;
                        tx_r      <= {tx_r[TX_W-2:0], 1'b0};
                        mosi_r    <= tx_r[TX_W-2];
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_DONE: begin
                    gap_cnt_r <= {GAP_W{1'b0}};
                    state_r   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= {GAP_W{1'b0}};
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a CLK_DIV=2 instance driven by directed and
// random requests against a behavioural SPI memory slave, plus a CLK_DIV=1
// instance for the minimum-divider case.
module tb_spi_master_ctrl;

    localparam int D   = 2;
    localparam int GAP = 2 * 2 * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid, req_valid1;
    logic       req_ready, req_ready1;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_valid1;
    logic [7:0] rsp_rdata, rsp_rdata1;
    logic       busy, busy1;
    logic       spi_sclk, spi_cs_n, spi_mosi, spi_sclk1, spi_cs_n1, spi_mosi1;
    logic       spi_miso  = 1'b0;
    logic       spi_miso1 = 1'b0;

    spi_master_ctrl #(.CLK_DIV(2), .ADDR_W(7), .DATA_W(8), .CS_GAP(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

    spi_master_ctrl #(.CLK_DIV(1), .ADDR_W(7), .DATA_W(8), .CS_GAP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
        .spi_sclk(spi_sclk1), .spi_cs_n(spi_cs_n1), .spi_mosi(spi_mosi1), .spi_miso(spi_miso1));

    int vec_cnt = 0;
    int err_cnt = 0;

    // Compare one observed value against its expectation and log a mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Power-on contents of the slave memory.
    function automatic logic [7:0] slave_def(input logic [6:0] a);
        return {a[3:0], a[3:0]} ^ 8'h69;
    endfunction

    // Bench-side memory model: what a read of each address must return.
    logic [7:0] ref_mem [128];
    bit         ref_wr  [128];
    function automatic logic [7:0] ref_read(input logic [6:0] a);
        return ref_wr[a] ? ref_mem[a] : slave_def(a);
    endfunction

    // Monitor / slave state (written only by the negedge process below).
    int         cyc = 0;
    int         cs_low_tot = 0, rsp_tot = 0, cs_fall_tot = 0;
    int         last_rsp_cyc = 0, last_cs_fall_cyc = 0;
    logic [7:0] last_rdata = 8'h00;
    int         s_rise = 0;
    logic [15:0] s_frame = 16'h0000, last_frame = 16'h0000;
    logic       s_rw = 1'b0;
    logic [7:0] s_rd = 8'h00;
    logic       cs_prev = 1'b1, sclk_prev = 1'b0;
    logic [7:0] slave_mem [128];
    bit         slave_wr  [128];

    int         cs1_low_tot = 0, rsp1_tot = 0, last_rsp1_cyc = 0;
    logic [7:0] last_rdata1 = 8'h00;
    int         s1_rise = 0, rise1_prev_cyc = 0, gap1_min = 1000, gap1_max = 0;
    logic [15:0] s1_frame = 16'h0000, last_frame1 = 16'h0000;
    logic       s1_rw = 1'b0;
    logic [7:0] s1_rd = 8'h00;
    logic       cs1_prev = 1'b1, sclk1_prev = 1'b0;

    // Bus monitor and mode-0 slave models, sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        // CLK_DIV=2 instance with a memory slave
        if (!spi_cs_n) cs_low_tot++;
        if (rsp_valid) begin rsp_tot++; last_rsp_cyc = cyc; last_rdata = rsp_rdata; end
        if (!spi_cs_n && cs_prev) begin cs_fall_tot++; last_cs_fall_cyc = cyc; end
        if (spi_cs_n) begin
            s_rise   = 0;
            spi_miso = 1'b0;
        end else begin
            if (spi_sclk && !sclk_prev) begin
                s_frame = {s_frame[14:0], spi_mosi};
                s_rise++;
                if (s_rise == 16) begin
                    last_frame = s_frame;
                    if (!s_frame[8]) begin
                        slave_mem[s_frame[15:9]] = s_frame[7:0];
                        slave_wr[s_frame[15:9]]  = 1'b1;
                    end
                end
            end
            if (!spi_sclk && sclk_prev) begin
                if (s_rise == 8) begin
                    s_rw = s_frame[0];
                    s_rd = slave_wr[s_frame[7:1]] ? slave_mem[s_frame[7:1]] : slave_def(s_frame[7:1]);
                end
                spi_miso = (s_rise >= 8 && s_rise <= 15 && s_rw) ? s_rd[15 - s_rise] : 1'b0;
            end
        end
        cs_prev   = spi_cs_n;
        sclk_prev = spi_sclk;

        // CLK_DIV=1 instance with an address-derived slave
        if (!spi_cs_n1) cs1_low_tot++;
        if (rsp_valid1) begin rsp1_tot++; last_rsp1_cyc = cyc; last_rdata1 = rsp_rdata1; end
        if (!spi_cs_n1 && cs1_prev) begin gap1_min = 1000; gap1_max = 0; end
        if (spi_cs_n1) begin
            s1_rise   = 0;
            spi_miso1 = 1'b0;
        end else begin
            if (spi_sclk1 && !sclk1_prev) begin
                if (s1_rise > 0) begin
                    if (cyc - rise1_prev_cyc < gap1_min) gap1_min = cyc - rise1_prev_cyc;
                    if (cyc - rise1_prev_cyc > gap1_max) gap1_max = cyc - rise1_prev_cyc;
                end
                rise1_prev_cyc = cyc;
                s1_frame = {s1_frame[14:0], spi_mosi1};
                s1_rise++;
                if (s1_rise == 16) last_frame1 = s1_frame;
            end
            if (!spi_sclk1 && sclk1_prev) begin
                if (s1_rise == 8) begin
                    s1_rw = s1_frame[0];
                    s1_rd = {1'b0, s1_frame[7:1]} ^ 8'h5A;
                end
                spi_miso1 = (s1_rise >= 8 && s1_rise <= 15 && s1_rw) ? s1_rd[15 - s1_rise] : 1'b0;
            end
        end
        cs1_prev   = spi_cs_n1;
        sclk1_prev = spi_sclk1;
    end

    // Wait (bounded) for the CLK_DIV=2 instance to be ready; returns that cycle.
    task automatic wait_ready(output int t);
        int n = 0;
        while (!req_ready && n < 500) begin @(negedge clk); #1; n++; end
        if (!req_ready) check_val("ready_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    // Wait (bounded) for a response beyond the given count.
    task automatic wait_rsp(input int base);
        int n = 0;
        while (rsp_tot == base && n < 2000) begin @(negedge clk); #1; n++; end
        if (rsp_tot == base) check_val("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Run one transaction on the CLK_DIV=2 instance and check frame, timing and response.
    task automatic do_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                           input bit poke);
        int a, rdy, r_base, l_base, f_base;
        logic [15:0] ef;
        logic [7:0]  er;
        ef = {addr, rw, (rw ? 8'h00 : wdata)};
        er = rw ? ref_read(addr) : 8'h00;
        wait_ready(a);
        r_base = rsp_tot; l_base = cs_low_tot; f_base = cs_fall_tot;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        @(negedge clk); #1;
        req_valid = 1'b0;
        if (poke) begin
            repeat (20) @(negedge clk);
            #1;
            req_valid = 1'b1; req_rw = ~rw; req_addr = ~addr; req_wdata = ~wdata;
            check_val("busy_mid_frame", {31'd0, busy}, 32'd1);
            @(negedge clk); #1;
            req_valid = 1'b0;
        end
        wait_rsp(r_base);
        if (!rw) begin ref_mem[addr] = wdata; ref_wr[addr] = 1'b1; end
        check_val("cs_fall_latency", last_cs_fall_cyc - a, 32'd1);
        check_val("cs_low_clks", cs_low_tot - l_base, 33 * D);
        check_val("rsp_at_cs_rise", last_rsp_cyc - last_cs_fall_cyc, 33 * D);
        check_val("mosi_frame", {16'd0, last_frame}, {16'd0, ef});
        check_val("rsp_rdata", {24'd0, last_rdata}, {24'd0, er});
        wait_ready(rdy);
        check_val("ready_return", rdy - last_rsp_cyc, GAP + 1);
        check_val("rsp_count", rsp_tot - r_base, 32'd1);
        check_val("frame_count", cs_fall_tot - f_base, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin : stim
        int a, r1, r_base, f_base, n;
        logic [6:0] ad;
        rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
        req_rw = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        check_val("rst_cs_n",      {31'd0, spi_cs_n},  32'd1);
        check_val("rst_sclk",      {31'd0, spi_sclk},  32'd0);
        check_val("rst_mosi",      {31'd0, spi_mosi},  32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rdata",     {24'd0, rsp_rdata}, 32'd0);
        check_val("rst_ready",     {31'd0, req_ready}, 32'd1);
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Directed write then read
        do_xfer(1'b0, 7'h2A, 8'hC5, 1'b0);
        do_xfer(1'b1, 7'h05, 8'hFF, 1'b0);
        do_xfer(1'b1, 7'h2A, 8'h00, 1'b0);

        // Two writes with req_valid held high across both
        wait_ready(a);
        r_base = rsp_tot;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h11; req_wdata = 8'hA1;
        @(negedge clk); #1;
        req_addr = 7'h12; req_wdata = 8'hB2;
        wait_rsp(r_base);
        r1 = last_rsp_cyc; f_base = cs_fall_tot;
        ref_mem[7'h11] = 8'hA1; ref_wr[7'h11] = 1'b1;
        check_val("b2b_frame1", {16'd0, last_frame}, {16'd0, 7'h11, 1'b0, 8'hA1});
        n = 0;
        while (cs_fall_tot == f_base && n < 200) begin @(negedge clk); #1; n++; end
        req_valid = 1'b0;
        check_val("b2b_accept_gap", last_cs_fall_cyc - r1, GAP + 2);
        wait_rsp(r_base + 1);
        ref_mem[7'h12] = 8'hB2; ref_wr[7'h12] = 1'b1;
        check_val("b2b_frame2", {16'd0, last_frame}, {16'd0, 7'h12, 1'b0, 8'hB2});
        do_xfer(1'b1, 7'h11, 8'h00, 1'b0);

        // Request pulsed while busy must be dropped
        do_xfer(1'b1, 7'h12, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            do_xfer(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'b0);
        end

        // Reset during sclk period 5 of a write
        do_xfer(1'b1, 7'h05, 8'h00, 1'b0);
        wait_ready(a);
        r_base = rsp_tot;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h33; req_wdata = 8'h5E;
        @(negedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (s_rise < 5 && n < 500) begin @(negedge clk); #1; n++; end
        rst_n = 1'b0;
        #1;
        check_val("abort_cs_n",  {31'd0, spi_cs_n},  32'd1);
        check_val("abort_sclk",  {31'd0, spi_sclk},  32'd0);
        check_val("abort_ready", {31'd0, req_ready}, 32'd1);
        check_val("abort_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_val("abort_no_rsp", rsp_tot - r_base, 32'd0);
        do_xfer(1'b1, 7'h7F, 8'h00, 1'b0);
        do_xfer(1'b1, 7'h33, 8'h00, 1'b0);

        // Minimum divider instance: one read
        ad = 7'($urandom);
        r_base = rsp1_tot; a = cyc; r1 = cs1_low_tot;
        check_val("d1_ready", {31'd0, req_ready1}, 32'd1);
        req_valid1 = 1'b1; req_rw = 1'b1; req_addr = ad; req_wdata = 8'h00;
        @(negedge clk); #1;
        req_valid1 = 1'b0;
        n = 0;
        while (rsp1_tot == r_base && n < 500) begin @(negedge clk); #1; n++; end
        check_val("d1_rsp_seen",   rsp1_tot - r_base, 32'd1);
        check_val("d1_rsp_time",   last_rsp1_cyc - a, 32'd34);
        check_val("d1_cs_low",     cs1_low_tot - r1, 32'd33);
        check_val("d1_sclk_min",   gap1_min, 32'd2);
        check_val("d1_sclk_max",   gap1_max, 32'd2);
        check_val("d1_frame",      {16'd0, last_frame1}, {16'd0, ad, 1'b1, 8'h00});
        check_val("d1_rdata",      {24'd0, last_rdata1}, {24'd0, {1'b0, ad} ^ 8'h5A});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
